cpu54_muticycle_mdu: RTL and testbench

Iterative multiply/divide unit for the 54-instruction multicycle CPU. It sits directly downstream of the multicycle controller. It consumes the controller's one-cycle MULT/MULTU/DIV/DIVU start strobes and operands from the register-file read ports, and holds the 64-bit result in HI/LO. The controller waits a fixed 33 cycles and then selects HI/LO for write-back. HI/LO are also directly writable for MTHI/MTLO.

---
 rtl/cpu54_muticycle_mdu.sv | 140 ++++++++++++++
 tb/tb_cpu54_muticycle_mdu.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu54_muticycle_mdu.sv
// Iterative 32x32 multiply / 32/32 divide unit for the multicycle CPU.
// Radix-2 shift-add multiply and restoring divide on magnitudes; the sign is fixed up on the last edge.
module cpu54_muticycle_mdu (
    input  logic        clock_in,
    input  logic        reset_signal,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [1:0]  dbg_state
);
    // start is taken only in IDLE (busy=0) and wins over hi_we/lo_we in that cycle;
    // done pulses for exactly one cycle, 33 edges after the accepting edge.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic        r_is_div;
    logic        r_psign;
    logic        r_qsign;
    logic        r_rsign;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [63:0] r_acc;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_signed;
    logic [31:0] w_a_abs;
    logic [31:0] w_b_abs;
    logic [32:0] w_msum;
    logic [32:0] w_rem_sh;
    logic        w_ge;
    logic [31:0] w_sub;
    logic [63:0] w_prod_fix;
    logic [31:0] w_rem_fix;
    logic [31:0] w_quot_fix;

    assign w_signed = ~op[0];
    assign w_a_abs  = (w_signed && a[31]) ? (~a + 32'd1) : a;
    assign w_b_abs  = (w_signed && b[31]) ? (~b + 32'd1) : b;

    // Multiply: r_a is the multiplicand, r_b shifts right as the multiplier.
    assign w_msum   = {1'b0, r_acc[63:32]} + {1'b0, r_a};

    // Divide: r_acc = {rem, quot}; dividend bits are shifted in from the top of r_a.
    assign w_rem_sh = {r_acc[63:32], r_a[31]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_b});
    assign w_sub    = w_rem_sh[31:0] - r_b;

    assign w_prod_fix = r_psign ? (~r_acc + 64'd1) : r_acc;
    assign w_rem_fix  = r_rsign ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
    assign w_quot_fix = r_qsign ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];

    always_ff @(posedge clock_in) begin
        if (reset_signal) begin
            r_state  <= S_IDLE;
            r_cnt    <= 6'd0;
            r_is_div <= 1'b0;
            r_psign  <= 1'b0;
            r_qsign  <= 1'b0;
            r_rsign  <= 1'b0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_acc    <= 64'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_RUN;
                        r_busy   <= 1'b1;
                        r_cnt    <= 6'd0;
                        r_is_div <= op[1];
                        r_a      <= w_a_abs;
                        r_b      <= w_b_abs;
                        r_psign  <= w_signed & (a[31] ^ b[31]);
                        // A zero divisor leaves the all-ones quotient uncorrected; the
                        // remainder correction then restores the raw dividend.
                        r_qsign  <= w_signed & (a[31] ^ b[31]) & (b != 32'd0);
                        r_rsign  <= w_signed & a[31];
                        r_acc    <= 64'd0;
                    end else begin
                        if (hi_we) r_hi <= wdata;
                        if (lo_we) r_lo <= wdata;
                    end
                end
                S_RUN: begin
                    if (r_is_div) begin
                        r_acc <= w_ge ? {w_sub, r_acc[30:0], 1'b1}
                                      : {w_rem_sh[31:0], r_acc[30:0], 1'b0};
                        r_a   <= {r_a[30:0], 1'b0};
                    end else begin
                        r_acc <= r_b[0] ? {w_msum, r_acc[31:1]} : {1'b0, r_acc[63:1]};
                        r_b   <= {1'b0, r_b[31:1]};
                    end
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31) r_state <= S_FIX;
                end
                S_FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quot_fix;
                    end else begin
                        r_hi <= w_prod_fix[63:32];
                        r_lo <= w_prod_fix[31:0];
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_cnt   <= 6'd0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign dbg_state = r_state;
endmodule

// File: tb/tb_cpu54_muticycle_mdu.sv
// Bench for cpu54_muticycle_mdu: directed and random MULT/DIV against an arithmetic model,
// plus MTHI/MTLO, start-while-busy, back-to-back and mid-operation reset scenarios.
module tb_cpu54_muticycle_mdu;
    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  dbg_state;

    int tests_run = 0;
    int fails = 0;

    cpu54_muticycle_mdu dut (
        .clock_in(clk), .reset_signal(rst), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Returns {hi, lo} as the CPU architecture defines them, from plain integer arithmetic.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] ux, uy, res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        res = 64'd0;
        case (o)
            2'd0: begin q = sx * sy; res = q; end
            2'd1: res = ux * uy;
            2'd2: begin
                if (y == 32'd0) res = {x, 32'hFFFFFFFF};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (y == 32'd0) res = {x, 32'hFFFFFFFF};
                else res = {32'(x % y), 32'(x / y)};
            end
        endcase
        return res;
    endfunction

    // Caller is at a negedge; start is seen on the next posedge (E0), task returns at the negedge after E0.
    task automatic do_start(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom);
        a = $urandom;
        b = $urandom;
    endtask

    // Counts negedges from the current one until done is seen (k=0 is the negedge after E0).
    task automatic wait_done(output int dk, output int bcnt, output logic [31:0] h, output logic [31:0] l);
        int k;
        dk = -1;
        bcnt = 0;
        h = 32'd0;
        l = 32'd0;
        k = 0;
        while (dk < 0 && k <= 40) begin
            if (done) begin
                dk = k;
                h = hi;
                l = lo;
            end else begin
                if (busy) bcnt++;
                @(negedge clk);
                k++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy, done, hi, lo, dbg_state} !== 68'd0) begin
            fails++;
            $display("FAIL reset_hold: busy=%b done=%b hi=%h lo=%h st=%0d required all zero", busy, done, hi, lo, dbg_state);
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({busy, done, hi, lo, dbg_state} !== 68'd0) begin
            fails++;
            $display("FAIL reset_release: busy=%b done=%b hi=%h lo=%h st=%0d required all zero", busy, done, hi, lo, dbg_state);
        end
    endtask

    task automatic test_directed();
        logic [1:0]  t_op[8]  = '{2'd1, 2'd0, 2'd0, 2'd2, 2'd3, 2'd2, 2'd3, 2'd2};
        logic [31:0] t_a[8]   = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFF9,
                                  32'h7, 32'h80000000, 32'h12345678, 32'hFFFFFFF9};
        logic [31:0] t_b[8]   = '{32'hFFFFFFFF, 32'h5, 32'h80000000, 32'h2,
                                  32'h2, 32'hFFFFFFFF, 32'h0, 32'h0};
        logic [63:0] t_exp[8] = '{64'hFFFFFFFE_00000001, 64'hFFFFFFFF_FFFFFFF1,
                                  64'h40000000_00000000, 64'hFFFFFFFF_FFFFFFFD,
                                  64'h00000001_00000003, 64'h00000000_80000000,
                                  64'h12345678_FFFFFFFF, 64'hFFFFFFF9_FFFFFFFF};
        int dk, bcnt;
        logic [31:0] h, l;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            do_start(t_op[i], t_a[i], t_b[i]);
            wait_done(dk, bcnt, h, l);
            tests_run++;
            if ({h, l} !== t_exp[i]) begin
                fails++;
                $display("FAIL directed_result[%0d]: got %h_%h required %h", i, h, l, t_exp[i]);
            end
            tests_run++;
            if (dk != 33 || bcnt != 33 || busy !== 1'b0) begin
                fails++;
                $display("FAIL directed_timing[%0d]: done_at=%0d busy_cycles=%0d busy_at_done=%b required 33/33/0", i, dk, bcnt, busy);
            end
            @(negedge clk);
            tests_run++;
            if (done !== 1'b0) begin
                fails++;
                $display("FAIL directed_done_width[%0d]: done=%b required 0", i, done);
            end
        end
    endtask

    task automatic test_random();
        int dk, bcnt;
        logic [31:0] h, l, x, y;
        logic [1:0] o;
        logic [63:0] exp_v;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            case (i % 4)
                0: y = 32'd0;
                1: y = 32'($urandom_range(1, 15));
                default: y = $urandom;
            endcase
            if (i % 5 == 0) x = {x[31], 31'($urandom_range(0, 1000))};
            exp_v = ref_model(o, x, y);
            @(negedge clk);
            do_start(o, x, y);
            wait_done(dk, bcnt, h, l);
            tests_run++;
            if ({h, l} !== exp_v || dk != 33) begin
                fails++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h_%h at %0d required %h at 33", i, o, x, y, h, l, dk, exp_v);
            end
        end
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] h0;
        int dk, bcnt;
        logic [31:0] h, l;
        @(negedge clk);
        h0 = hi;
        lo_we = 1'b1;
        wdata = 32'hAAAA5555;
        @(negedge clk);
        lo_we = 1'b0;
        tests_run++;
        if (lo !== 32'hAAAA5555 || hi !== h0 || done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL mtlo: lo=%h hi=%h done=%b busy=%b required lo=aaaa5555 hi=%h done=0 busy=0", lo, hi, done, busy, h0);
        end
        hi_we = 1'b1;
        wdata = 32'h13572468;
        @(negedge clk);
        hi_we = 1'b0;
        tests_run++;
        if (hi !== 32'h13572468 || lo !== 32'hAAAA5555 || done !== 1'b0) begin
            fails++;
            $display("FAIL mthi: hi=%h lo=%h done=%b required hi=13572468 lo=aaaa5555 done=0", hi, lo, done);
        end
        // start and hi_we in the same cycle: the write must be dropped.
        hi_we = 1'b1;
        wdata = 32'hFFFF0000;
        do_start(2'd3, 32'd100, 32'd7);
        hi_we = 1'b0;
        tests_run++;
        if (hi !== 32'h13572468 || busy !== 1'b1) begin
            fails++;
            $display("FAIL start_wins: hi=%h busy=%b required hi=13572468 busy=1", hi, busy);
        end
        wait_done(dk, bcnt, h, l);
        tests_run++;
        if (h !== 32'd2 || l !== 32'd14 || dk != 33) begin
            fails++;
            $display("FAIL start_wins_result: got %h_%h at %0d required 00000002_0000000e at 33", h, l, dk);
        end
    endtask

    task automatic test_busy_ignore();
        int dk, bcnt;
        logic [31:0] h, l, h_run;
        @(negedge clk);
        do_start(2'd1, 32'd3, 32'd4);
        repeat (10) @(negedge clk);
        h_run = hi;
        start = 1'b1;
        op = 2'd0;
        a = 32'd5;
        b = 32'd7;
        hi_we = 1'b1;
        wdata = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        tests_run++;
        if (hi !== h_run) begin
            fails++;
            $display("FAIL busy_hi_we: hi=%h required %h", hi, h_run);
        end
        wait_done(dk, bcnt, h, l);
        tests_run++;
        if (h !== 32'd0 || l !== 32'hC || dk != 22) begin
            fails++;
            $display("FAIL busy_ignore_result: got %h_%h at %0d required 00000000_0000000c at 22", h, l, dk);
        end
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL busy_ignore_after: busy=%b done=%b required 0/0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        int dk, bcnt;
        logic [31:0] h, l, x1, y1, x2, y2;
        logic [63:0] e1, e2;
        x1 = $urandom; y1 = $urandom;
        x2 = $urandom; y2 = 32'($urandom_range(1, 100000));
        e1 = ref_model(2'd0, x1, y1);
        e2 = ref_model(2'd2, x2, y2);
        @(negedge clk);
        do_start(2'd0, x1, y1);
        wait_done(dk, bcnt, h, l);
        tests_run++;
        if ({h, l} !== e1 || dk != 33) begin
            fails++;
            $display("FAIL b2b_first: got %h_%h at %0d required %h at 33", h, l, dk, e1);
        end
        do_start(2'd2, x2, y2);
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL b2b_accept: busy=%b done=%b required 1/0", busy, done);
        end
        wait_done(dk, bcnt, h, l);
        tests_run++;
        if ({h, l} !== e2 || dk != 33 || bcnt != 33) begin
            fails++;
            $display("FAIL b2b_second: got %h_%h at %0d busy=%0d required %h at 33 busy=33", h, l, dk, bcnt, e2);
        end
    endtask

    task automatic test_reset_mid();
        int dk, bcnt, ndone;
        logic [31:0] h, l;
        @(negedge clk);
        do_start(2'd2, 32'hFFFF1234, 32'd17);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || dbg_state !== 2'd0) begin
            fails++;
            $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h st=%0d required all zero", busy, done, hi, lo, dbg_state);
        end
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) ndone++;
            @(negedge clk);
        end
        tests_run++;
        if (ndone != 0) begin
            fails++;
            $display("FAIL reset_mid_quiet: %0d cycles with done/busy required 0", ndone);
        end
        do_start(2'd3, 32'd1000, 32'd7);
        wait_done(dk, bcnt, h, l);
        tests_run++;
        if (h !== 32'd6 || l !== 32'd142 || dk != 33) begin
            fails++;
            $display("FAIL reset_mid_restart: got %h_%h at %0d required 00000006_0000008e at 33", h, l, dk);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        op = 2'd0;
        a = 32'd0;
        b = 32'd0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = 32'd0;
        test_reset();
        test_directed();
        test_random();
        test_mthi_mtlo();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
